// File: rtl/tf_pkg.sv
// tf_pkg -- shared definitions for the horizontal twiddle-factor sequencer.
//
// Holds the default block parameters, the sequencer state encoding and the
// forward / inverse twiddle tables (TF_NSTAGE x TF_DEPTH words of
// TF_P_WIDTH bits).
//
// Each word is laid out as {re[63:32], im[31:0]}. The inverse-root table is
// the complex conjugate of the forward table: the real half is shared and
// the imaginary half is two's-complement negated.
package tf_pkg;

  localparam int TF_P_WIDTH  = 64;
  localparam int TF_NSTAGE   = 4;
  localparam int TF_DEPTH    = 64;
  localparam int TF_HOLD     = 16;
  localparam int TF_SC_WIDTH = 3;

  // Table generator constants: entry k = TF_SEED + k * TF_STEP,
  // with k = stage * TF_DEPTH + index.
  localparam logic [63:0] TF_SEED = 64'h99e61fc5adeb5a6d;
  localparam logic [63:0] TF_STEP = 64'h9e3779b97f4a7c15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } tf_state_t;

  typedef logic [TF_NSTAGE-1:0][TF_DEPTH-1:0][TF_P_WIDTH-1:0] tf_table_t;

  localparam int TF_FLAT_W = $bits(tf_table_t);

  // Builds the table bottom-up so that element [s][i] lands at bit offset
  // (s * TF_DEPTH + i) * TF_P_WIDTH without any variable indexing.
  function automatic tf_table_t tf_gen_table(input logic inv);
    logic [TF_FLAT_W-1:0]  flat;
    logic [TF_P_WIDTH-1:0] w;
    logic [TF_P_WIDTH-1:0] e;
    flat = {TF_FLAT_W{1'b0}};
    for (int k = TF_NSTAGE * TF_DEPTH - 1; k >= 0; k--) begin
      w = TF_SEED + TF_STEP * 64'(k);
      if (inv) begin
        e = {w[63:32], 32'h0000_0000 - w[31:0]};
      end else begin
        e = w;
      end
      flat = {flat[TF_FLAT_W-TF_P_WIDTH-1:0], e};
    end
    return flat;
  endfunction

  localparam tf_table_t TF_FWD_TABLE = tf_gen_table(1'b0);
  localparam tf_table_t TF_INV_TABLE = tf_gen_table(1'b1);

endpackage

// File: rtl/tf_rom.sv
// tf_rom -- twiddle table storage with a registered one-cycle read.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous reset, active-high (1 = reset)
//   rd_en  : load rdata with the addressed word at the next clock edge
//   inv    : select the inverse-root table instead of the forward table
//   stage  : stage table to read; stages >= NSTAGE read as zero
//   addr   : factor index within the stage table
//   rdata  : registered read data, holds its value while rd_en is low
module tf_rom
  import tf_pkg::*;
#(
  parameter int P_WIDTH  = TF_P_WIDTH,
  parameter int NSTAGE   = TF_NSTAGE,
  parameter int DEPTH    = TF_DEPTH,
  parameter int SC_WIDTH = TF_SC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic                     inv,
  input  logic [SC_WIDTH-1:0]      stage,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [P_WIDTH-1:0]       rdata
);

  localparam int SW  = $clog2(TF_NSTAGE);
  localparam int TIW = $clog2(TF_DEPTH);

  logic [SW-1:0]         stage_ix_s;
  logic [TIW-1:0]        addr_ix_s;
  logic                  hit_s;
  logic [TF_P_WIDTH-1:0] word_s;

  // Table lookup; anything outside the populated stages reads as zero.
  always_comb begin
    stage_ix_s = SW'(stage);
    addr_ix_s  = TIW'(addr);
    hit_s      = (int'(stage) < NSTAGE) && (int'(stage) < TF_NSTAGE) &&
                 (int'(addr) < TF_DEPTH);
    if (!hit_s) begin
      word_s = {TF_P_WIDTH{1'b0}};
    end else if (inv) begin
      word_s = TF_INV_TABLE[stage_ix_s][addr_ix_s];
    end else begin
      word_s = TF_FWD_TABLE[stage_ix_s][addr_ix_s];
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rdata <= {P_WIDTH{1'b0}};
    end else if (rd_en) begin
      rdata <= P_WIDTH'(word_s);
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/horizontal_tf_seq.sv
// horizontal_tf_seq -- walks one stage's twiddle table, presenting each
// factor for HOLD accepted beats before moving to the next index.
//
// Ports:
//   clk        : clock
//   rst_n      : asynchronous reset, active-high (1 = reset)
//   inv        : (only with HORIZONTAL_TF_INV_EN) use the inverse-root table,
//                sampled on an accepted start
//   start      : one-cycle request to begin a sequence, honoured only in IDLE
//   stage_sel  : stage table to walk, sampled on an accepted start
//   start_idx  : first factor index, sampled on an accepted start
//   out_ready  : consumer accepts Q this cycle
//   out_valid  : Q holds a valid factor
//   Q          : current twiddle factor
//   idx        : table index of the factor on Q
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle pulse when a sequence completes
//
// Configuration macro: HORIZONTAL_TF_INV_EN adds the inv port; without it
// the forward table is always used.
module horizontal_tf_seq
  import tf_pkg::*;
#(
  parameter int P_WIDTH  = TF_P_WIDTH,
  parameter int NSTAGE   = TF_NSTAGE,
  parameter int DEPTH    = TF_DEPTH,
  parameter int HOLD     = TF_HOLD,
  parameter int SC_WIDTH = TF_SC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef HORIZONTAL_TF_INV_EN
  input  logic                     inv,
`endif
  input  logic                     start,
  input  logic [SC_WIDTH-1:0]      stage_sel,
  input  logic [$clog2(DEPTH)-1:0] start_idx,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [P_WIDTH-1:0]       Q,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(DEPTH);
  // Wide enough for HOLD up to 256.
  localparam int BW = 9;

  tf_state_t           state_r;
  tf_state_t           state_s;
  logic [SC_WIDTH-1:0] stage_r;
  logic                inv_r;
  logic                inv_in_s;
  logic [IW-1:0]       rd_idx_r;
  logic [IW-1:0]       idx_cnt_r;
  logic [BW-1:0]       beat_cnt_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                done_r;
  logic                beat_s;
  logic                hold_end_s;
  logic                seq_end_s;
  logic                rom_en_s;
  logic [IW-1:0]       rom_addr_s;

`ifdef HORIZONTAL_TF_INV_EN
  assign inv_in_s = inv;
`else
  assign inv_in_s = 1'b0;
`endif

  // out_valid_r is only ever high in RUN, so a beat implies RUN.
  assign beat_s     = out_valid_r && out_ready;
  assign hold_end_s = beat_s && (beat_cnt_r == BW'(HOLD - 1));
  assign seq_end_s  = hold_end_s && (idx_cnt_r == IW'(DEPTH - 1));

  // Next state and ROM read control. On the last beat of a hold the ROM is
  // read at rd_idx + 1 so the next factor appears with the new index.
  always_comb begin
    state_s    = state_r;
    rom_en_s   = 1'b0;
    rom_addr_s = rd_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s    = ST_RUN;
        rom_en_s   = 1'b1;
        rom_addr_s = rd_idx_r;
      end
      ST_RUN: begin
        if (hold_end_s) begin
          rom_en_s   = 1'b1;
          rom_addr_s = rd_idx_r + IW'(1);
          if (seq_end_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == ST_RUN);
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_DONE);
    end
  end

  // Sequence context: latched request fields plus beat and index counters.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      stage_r    <= {SC_WIDTH{1'b0}};
      inv_r      <= 1'b0;
      rd_idx_r   <= {IW{1'b0}};
      idx_cnt_r  <= {IW{1'b0}};
      beat_cnt_r <= {BW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            stage_r    <= stage_sel;
            inv_r      <= inv_in_s;
            rd_idx_r   <= start_idx;
            idx_cnt_r  <= {IW{1'b0}};
            beat_cnt_r <= {BW{1'b0}};
          end
        end
        ST_RUN: begin
          if (hold_end_s) begin
            beat_cnt_r <= {BW{1'b0}};
            rd_idx_r   <= rd_idx_r + IW'(1);
            idx_cnt_r  <= idx_cnt_r + IW'(1);
          end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + BW'(1);
          end
        end
        default: begin
          beat_cnt_r <= beat_cnt_r;
        end
      endcase
    end
  end

  tf_rom #(
    .P_WIDTH (P_WIDTH),
    .NSTAGE  (NSTAGE),
    .DEPTH   (DEPTH),
    .SC_WIDTH(SC_WIDTH)
  ) u_rom (
    .clk  (clk),
    .rst_n(rst_n),
    .rd_en(rom_en_s),
    .inv  (inv_r),
    .stage(stage_r),
    .addr (rom_addr_s),
    .rdata(Q)
  );

  assign out_valid = out_valid_r;
  assign idx       = rd_idx_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_horizontal_tf_seq.sv
// Directed bench for horizontal_tf_seq: one instance with the default
// HOLD = 16 and one with HOLD = 1, sharing clock, reset and ready.
module tb_horizontal_tf_seq;
  import tf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [2:0]  stage_sel = 3'd0;
  logic [5:0]  start_idx = 6'd0;
  logic        out_ready = 1'b0;
  logic        inv = 1'b0;

  logic        ov0, busy0, done0, ov1, busy1, done1;
  logic [63:0] q0, q1;
  logic [5:0]  idx0, idx1;

  logic        sel = 1'b0;
  logic        m_ov, m_busy, m_done;
  logic [63:0] m_q;
  logic [5:0]  m_idx;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  horizontal_tf_seq #(.P_WIDTH(64), .NSTAGE(4), .DEPTH(64), .HOLD(16), .SC_WIDTH(3)) dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef HORIZONTAL_TF_INV_EN
    .inv(inv),
`endif
    .start(start0), .stage_sel(stage_sel), .start_idx(start_idx), .out_ready(out_ready),
    .out_valid(ov0), .Q(q0), .idx(idx0), .busy(busy0), .done(done0)
  );

  horizontal_tf_seq #(.P_WIDTH(64), .NSTAGE(4), .DEPTH(64), .HOLD(1), .SC_WIDTH(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef HORIZONTAL_TF_INV_EN
    .inv(inv),
`endif
    .start(start1), .stage_sel(stage_sel), .start_idx(start_idx), .out_ready(out_ready),
    .out_valid(ov1), .Q(q1), .idx(idx1), .busy(busy1), .done(done1)
  );

  always_comb begin
    m_ov   = sel ? ov1 : ov0;
    m_busy = sel ? busy1 : busy0;
    m_done = sel ? done1 : done0;
    m_q    = sel ? q1 : q0;
    m_idx  = sel ? idx1 : idx0;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  function automatic logic [63:0] exp_q(input logic [2:0] stg, input logic [5:0] i, input logic iv);
    logic [1:0] s2;
    s2 = stg[1:0];
    if (stg >= 3'd4) return 64'h0;
    else if (iv)     return TF_INV_TABLE[s2][i];
    else             return TF_FWD_TABLE[s2][i];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_q"},     m_q,            64'h0);
    check_val({tag, "_idx"},   64'(m_idx),     64'd0);
    check_val({tag, "_valid"}, 64'(m_ov),      64'd0);
    check_val({tag, "_busy"},  64'(m_busy),    64'd0);
    check_val({tag, "_done"},  64'(m_done),    64'd0);
  endtask

  // Starts a sequence on the selected instance and follows it for stop_at
  // accepted beats, checking Q/idx every cycle against a beat/index model.
  task automatic run_seq(input int hold, input logic [2:0] stg, input logic [5:0] sidx,
                         input logic iv, input logic [63:0] first_exp, input int stop_at,
                         input bit stall, input bit spam);
    int         beats, bc, cyc, stalls;
    logic [5:0] ei;
    logic       rdy;
    stage_sel = stg;
    start_idx = sidx;
    inv       = iv;
    out_ready = 1'b1;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check_val("fetch_busy",  64'(m_busy), 64'd1);
    check_val("fetch_valid", 64'(m_ov),   64'd0);
    tick();
    check_val("first_q", m_q, first_exp);
    beats = 0; bc = 0; cyc = 0; stalls = 0; ei = sidx;
    while (beats < stop_at && cyc < 3000) begin
      check_val("run_valid", 64'(m_ov),   64'd1);
      check_val("run_q",     m_q,         exp_q(stg, ei, iv));
      check_val("run_idx",   64'(m_idx),  64'(ei));
      check_val("run_done",  64'(m_done), 64'd0);
      rdy = !(stall && beats == 8 && stalls < 5);
      if (!rdy) stalls++;
      out_ready = rdy;
      if (spam && beats == 500) begin
        stage_sel = 3'd2;
        start_idx = 6'd5;
        set_start(1'b1);
      end else begin
        set_start(1'b0);
      end
      tick();
      cyc++;
      if (rdy) begin
        beats++;
        bc++;
        if (bc == hold) begin
          bc = 0;
          ei = ei + 6'd1;
        end
      end
    end
    set_start(1'b0);
    out_ready = 1'b1;
    check_val("beat_total", 64'(beats), 64'(stop_at));
  endtask

  task automatic check_done_pulse(input string tag);
    check_val({tag, "_end_valid"}, 64'(m_ov),   64'd0);
    check_val({tag, "_end_done"},  64'(m_done), 64'd1);
    check_val({tag, "_end_busy"},  64'(m_busy), 64'd1);
    tick();
    check_val({tag, "_post_done"}, 64'(m_done), 64'd0);
    check_val({tag, "_post_busy"}, 64'(m_busy), 64'd0);
  endtask

  initial begin
    // Reset state of both instances.
    repeat (3) tick();
    sel = 1'b0; #1;
    check_idle_outputs("rst0");
    sel = 1'b1; #1;
    check_idle_outputs("rst1");
    rst_n = 1'b0;
    sel = 1'b0;
    tick();
    check_val("idle_busy", 64'(m_busy), 64'd0);

    // Stage 0 from index 1, 5-cycle stall mid-hold, stray start during RUN,
    // completion after 1024 beats.
    run_seq(16, 3'd0, 6'd1, 1'b0, 64'h381d997f2d35d682, 1024, 1'b1, 1'b1);
    check_done_pulse("full");

    // Start in the cycle after done, then reset at beat 300.
    run_seq(16, 3'd1, 6'd62, 1'b0, exp_q(3'd1, 6'd62, 1'b0), 300, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("abort_async");
    tick();
    check_idle_outputs("abort_next");
    rst_n = 1'b0;
    tick();
    check_val("abort_no_done", 64'(m_done), 64'd0);
    run_seq(16, 3'd0, 6'd1, 1'b0, 64'h381d997f2d35d682, 40, 1'b0, 1'b0);

    // HOLD = 1 instance: wrap from index 63.
    sel = 1'b1; #1;
    run_seq(1, 3'd0, 6'd63, 1'b0, exp_q(3'd0, 6'd63, 1'b0), 64, 1'b0, 1'b0);
    check_done_pulse("wrap");

    // Unpopulated stage reads as zero with normal timing.
    run_seq(1, 3'd5, 6'd10, 1'b0, 64'h0, 64, 1'b0, 1'b0);
    check_done_pulse("badstage");

`ifdef HORIZONTAL_TF_INV_EN
    // Inverse-root table: conjugate of the forward word.
    run_seq(1, 3'd0, 6'd1, 1'b1, 64'h381d997fd2ca297e, 64, 1'b0, 1'b0);
    check_done_pulse("inv");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
